// File: rtl/packet_ref_table.sv
// Packet Reference Table: slot allocator, beat-wise packet buffer and reader
// serving the malicious-packet detector's PRT method interface.
module packet_ref_table #(
  parameter int DATA_WIDTH = 32,
  parameter int NUM_SLOTS  = 16,
  parameter int MAX_BEATS  = 16,
  localparam int SW = $clog2(NUM_SLOTS)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  EN_start_writing_prt_entry,
  output logic                  RDY_start_writing_prt_entry,
  output logic [SW-1:0]         start_writing_prt_entry,
  input  logic                  EN_write_prt_entry,
  output logic                  RDY_write_prt_entry,
  input  logic [DATA_WIDTH-1:0] write_prt_entry_data,
  input  logic                  EN_finish_writing_prt_entry,
  output logic                  RDY_finish_writing_prt_entry,
  input  logic                  EN_invalidate_prt_entry,
  output logic                  RDY_invalidate_prt_entry,
  input  logic [SW-1:0]         invalidate_prt_entry_slot,
  input  logic                  EN_start_reading_prt_entry,
  output logic                  RDY_start_reading_prt_entry,
  input  logic [SW-1:0]         start_reading_prt_entry_slot,
  input  logic                  EN_read_prt_entry,
  output logic                  RDY_read_prt_entry,
  output logic [DATA_WIDTH:0]   read_prt_entry,
  output logic                  is_prt_slot_free,
  output logic                  RDY_is_prt_slot_free
);
  localparam int BW = $clog2(MAX_BEATS);
  localparam int CW = BW + 1;

  typedef enum logic { W_IDLE, W_ACTIVE } w_state_t;
  typedef enum logic { R_IDLE, R_ACTIVE } r_state_t;

  w_state_t w_state, w_state_nxt;
  r_state_t r_state, r_state_nxt;

  logic [SW-1:0]                wslot, rslot, alloc;
  logic [CW-1:0]                wcnt, fin_cnt;
  logic [BW-1:0]                rptr;
  logic                         rinv;
  logic [NUM_SLOTS-1:0]         valid, free;
  logic [NUM_SLOTS-1:0][CW-1:0] slot_len;
  logic [DATA_WIDTH-1:0]        mem [NUM_SLOTS][MAX_BEATS];

  logic sw_fire, wr_fire, fin_fire, inv_fire, sr_fire, rd_fire, inv_hits_w, rd_last;

  // Free = neither valid nor reserved by the open write session
  always_comb begin
    free = ~valid;
    if (w_state == W_ACTIVE) free[wslot] = 1'b0;
    alloc = '0;
    for (int i = NUM_SLOTS - 1; i >= 0; i--)
      if (free[i]) alloc = SW'(i);
  end

  assign RDY_start_writing_prt_entry  = (w_state == W_IDLE) && (|free);
  assign start_writing_prt_entry      = alloc;
  assign RDY_write_prt_entry          = (w_state == W_ACTIVE) && (wcnt < CW'(MAX_BEATS));
  assign RDY_finish_writing_prt_entry = (w_state == W_ACTIVE);
  assign RDY_invalidate_prt_entry     = (r_state == R_IDLE);
  assign RDY_start_reading_prt_entry  = (r_state == R_IDLE);
  assign RDY_read_prt_entry           = (r_state == R_ACTIVE);
  assign is_prt_slot_free             = |free;
  assign RDY_is_prt_slot_free         = 1'b1;

  assign sw_fire  = EN_start_writing_prt_entry  && RDY_start_writing_prt_entry;
  assign wr_fire  = EN_write_prt_entry          && RDY_write_prt_entry;
  assign fin_fire = EN_finish_writing_prt_entry && RDY_finish_writing_prt_entry;
  assign inv_fire = EN_invalidate_prt_entry     && RDY_invalidate_prt_entry;
  assign sr_fire  = EN_start_reading_prt_entry  && RDY_start_reading_prt_entry;
  assign rd_fire  = EN_read_prt_entry           && RDY_read_prt_entry;

  assign inv_hits_w = inv_fire && (w_state == W_ACTIVE) && (invalidate_prt_entry_slot == wslot);
  // A beat written in the finishing cycle is part of the packet
  assign fin_cnt    = wcnt + CW'(wr_fire);
  // A session opened on an invalid slot yields a single terminating beat
  assign rd_last    = rinv || ({1'b0, rptr} == slot_len[rslot] - CW'(1));

  always_comb begin
    w_state_nxt = w_state;
    case (w_state)
      W_IDLE:   if (sw_fire) w_state_nxt = W_ACTIVE;
      W_ACTIVE: if (fin_fire || inv_hits_w) w_state_nxt = W_IDLE;
      default:  w_state_nxt = W_IDLE;
    endcase
  end

  always_comb begin
    r_state_nxt = r_state;
    case (r_state)
      R_IDLE:   if (sr_fire) r_state_nxt = R_ACTIVE;
      R_ACTIVE: if (rd_fire && rd_last) r_state_nxt = R_IDLE;
      default:  r_state_nxt = R_IDLE;
    endcase
  end

  always_comb begin
    read_prt_entry = '0;
    if (r_state == R_ACTIVE)
      read_prt_entry = rinv ? {1'b1, {DATA_WIDTH{1'b0}}} : {rd_last, mem[rslot][rptr]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      w_state  <= W_IDLE;
      r_state  <= R_IDLE;
      wslot    <= '0;
      wcnt     <= '0;
      rslot    <= '0;
      rptr     <= '0;
      rinv     <= 1'b0;
      valid    <= '0;
      slot_len <= '0;
    end else begin
      w_state <= w_state_nxt;
      r_state <= r_state_nxt;
      if (sw_fire) begin
        wslot <= alloc;
        wcnt  <= '0;
      end else if (wr_fire) begin
        wcnt <= wcnt + CW'(1);
      end
      if (fin_fire && fin_cnt != '0) begin
        valid[wslot]    <= 1'b1;
        slot_len[wslot] <= fin_cnt;
      end
      // Invalidate is applied last so it also wins over a same-slot finish
      if (inv_fire) valid[invalidate_prt_entry_slot] <= 1'b0;
      if (sr_fire) begin
        rslot <= start_reading_prt_entry_slot;
        rptr  <= '0;
        rinv  <= ~valid[start_reading_prt_entry_slot];
      end else if (rd_fire && !rd_last) begin
        rptr <= rptr + BW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (wr_fire) mem[wslot][wcnt[BW-1:0]] <= write_prt_entry_data;
  end
endmodule

// File: tb/tb_packet_ref_table.sv
// Bench for packet_ref_table: directed scenarios plus randomized traffic,
// all checked against a slot/queue-level model of the table.
module tb_packet_ref_table;
  logic        clk = 0;
  logic        rst_n = 0;
  logic        EN_start_writing_prt_entry = 0, EN_write_prt_entry = 0, EN_finish_writing_prt_entry = 0;
  logic        EN_invalidate_prt_entry = 0, EN_start_reading_prt_entry = 0, EN_read_prt_entry = 0;
  logic [31:0] write_prt_entry_data = 0;
  logic [3:0]  invalidate_prt_entry_slot = 0, start_reading_prt_entry_slot = 0;
  logic        RDY_start_writing_prt_entry, RDY_write_prt_entry, RDY_finish_writing_prt_entry;
  logic        RDY_invalidate_prt_entry, RDY_start_reading_prt_entry, RDY_read_prt_entry;
  logic        is_prt_slot_free, RDY_is_prt_slot_free;
  logic [3:0]  start_writing_prt_entry;
  logic [32:0] read_prt_entry;

  int tests = 0, fails = 0;

  packet_ref_table dut (
    .clk(clk), .rst_n(rst_n),
    .EN_start_writing_prt_entry(EN_start_writing_prt_entry),
    .RDY_start_writing_prt_entry(RDY_start_writing_prt_entry),
    .start_writing_prt_entry(start_writing_prt_entry),
    .EN_write_prt_entry(EN_write_prt_entry), .RDY_write_prt_entry(RDY_write_prt_entry),
    .write_prt_entry_data(write_prt_entry_data),
    .EN_finish_writing_prt_entry(EN_finish_writing_prt_entry),
    .RDY_finish_writing_prt_entry(RDY_finish_writing_prt_entry),
    .EN_invalidate_prt_entry(EN_invalidate_prt_entry),
    .RDY_invalidate_prt_entry(RDY_invalidate_prt_entry),
    .invalidate_prt_entry_slot(invalidate_prt_entry_slot),
    .EN_start_reading_prt_entry(EN_start_reading_prt_entry),
    .RDY_start_reading_prt_entry(RDY_start_reading_prt_entry),
    .start_reading_prt_entry_slot(start_reading_prt_entry_slot),
    .EN_read_prt_entry(EN_read_prt_entry), .RDY_read_prt_entry(RDY_read_prt_entry),
    .read_prt_entry(read_prt_entry),
    .is_prt_slot_free(is_prt_slot_free), .RDY_is_prt_slot_free(RDY_is_prt_slot_free)
  );

  always #5 clk = ~clk;

  // Reference model: per-slot packets as valid flag, length and beat list
  bit          mv[16];
  int          mlen[16];
  logic [31:0] mdata[16][16];
  bit          mw_open, mr_open, mrinv;
  int          mwslot, mwcnt, mrslot, mrptr;

  function automatic void m_reset();
    for (int i = 0; i < 16; i++) begin mv[i] = 0; mlen[i] = 0; end
    mw_open = 0; mr_open = 0; mrinv = 0; mwslot = 0; mwcnt = 0; mrslot = 0; mrptr = 0;
  endfunction

  function automatic int m_lowest_free();
    for (int i = 0; i < 16; i++)
      if (!mv[i] && !(mw_open && mwslot == i)) return i;
    return -1;
  endfunction

  function automatic bit m_last();
    return mrinv || (mrptr == mlen[mrslot] - 1);
  endfunction

  function automatic logic [32:0] m_read();
    if (!mr_open) return 33'd0;
    if (mrinv) return {1'b1, 32'd0};
    return {m_last(), mdata[mrslot][mrptr]};
  endfunction

  function automatic void m_update();
    int lf, pwslot, pwcnt, c, islot, sslot;
    bit rdy_sw, rdy_w, wf, pwopen, rl;
    bit pv[16];
    lf = m_lowest_free();
    rdy_sw = !mw_open && lf >= 0;
    rdy_w = mw_open && mwcnt < 16;
    wf = EN_write_prt_entry && rdy_w;
    rl = m_last();
    pv = mv; pwslot = mwslot; pwcnt = mwcnt; pwopen = mw_open;
    islot = int'(invalidate_prt_entry_slot);
    sslot = int'(start_reading_prt_entry_slot);
    if (EN_start_writing_prt_entry && rdy_sw) begin mw_open = 1; mwslot = lf; mwcnt = 0; end
    if (wf) begin mdata[pwslot][pwcnt] = write_prt_entry_data; mwcnt = pwcnt + 1; end
    if (EN_finish_writing_prt_entry && pwopen) begin
      c = pwcnt + int'(wf);
      if (c > 0) begin mv[pwslot] = 1; mlen[pwslot] = c; end
      mw_open = 0;
    end
    if (EN_invalidate_prt_entry && !mr_open) begin
      mv[islot] = 0;
      if (pwopen && islot == pwslot) mw_open = 0;
    end
    if (EN_start_reading_prt_entry && !mr_open) begin
      mr_open = 1; mrslot = sslot; mrptr = 0; mrinv = !pv[sslot];
    end else if (EN_read_prt_entry && mr_open) begin
      if (rl) mr_open = 0; else mrptr++;
    end
  endfunction

  task automatic tick();
    m_update();
    @(posedge clk); #1;
    EN_start_writing_prt_entry = 0; EN_write_prt_entry = 0; EN_finish_writing_prt_entry = 0;
    EN_invalidate_prt_entry = 0; EN_start_reading_prt_entry = 0; EN_read_prt_entry = 0;
  endtask

  task automatic do_start_write(); EN_start_writing_prt_entry = 1; tick(); endtask
  task automatic do_write(input logic [31:0] d); EN_write_prt_entry = 1; write_prt_entry_data = d; tick(); endtask
  task automatic do_finish(); EN_finish_writing_prt_entry = 1; tick(); endtask
  task automatic do_inv(input int s); EN_invalidate_prt_entry = 1; invalidate_prt_entry_slot = 4'(s); tick(); endtask
  task automatic do_start_read(input int s); EN_start_reading_prt_entry = 1; start_reading_prt_entry_slot = 4'(s); tick(); endtask

  // {RDY_sw, sw_slot, RDY_w, RDY_f, RDY_inv, RDY_sr, RDY_r, read, free, RDY_free}
  function automatic logic [44:0] out_vec();
    return {RDY_start_writing_prt_entry, start_writing_prt_entry, RDY_write_prt_entry,
            RDY_finish_writing_prt_entry, RDY_invalidate_prt_entry, RDY_start_reading_prt_entry,
            RDY_read_prt_entry, read_prt_entry, is_prt_slot_free, RDY_is_prt_slot_free};
  endfunction
  localparam logic [44:0] RESET_VEC = {1'b1, 4'd0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 33'd0, 1'b1, 1'b1};

  task automatic test_reset();
    m_reset();
    #3;
    tests++;
    if (out_vec() !== RESET_VEC) begin
      fails++; $display("FAIL reset_outputs got %h want %h", out_vec(), RESET_VEC);
    end
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
    tests++;
    if (out_vec() !== RESET_VEC) begin
      fails++; $display("FAIL after_reset_release got %h want %h", out_vec(), RESET_VEC);
    end
  endtask

  task automatic test_basic();
    logic [31:0] a, b, c;
    a = $urandom; b = $urandom; c = $urandom;
    do_start_write(); do_write(a); do_write(b); do_write(c); do_finish();
    tests++;
    if (start_writing_prt_entry !== 4'd1) begin
      fails++; $display("FAIL basic_next_alloc got %0d want 1", start_writing_prt_entry);
    end
    do_start_read(0);
    tests++;
    if (read_prt_entry !== {1'b0, a}) begin fails++; $display("FAIL basic_beat0 got %h want %h", read_prt_entry, {1'b0, a}); end
    EN_read_prt_entry = 1; tick();
    tests++;
    if (read_prt_entry !== {1'b0, b}) begin fails++; $display("FAIL basic_beat1 got %h want %h", read_prt_entry, {1'b0, b}); end
    EN_read_prt_entry = 1; tick();
    tests++;
    if (read_prt_entry !== {1'b1, c}) begin fails++; $display("FAIL basic_beat2 got %h want %h", read_prt_entry, {1'b1, c}); end
    EN_read_prt_entry = 1; tick();
    tests++;
    if (RDY_read_prt_entry !== 1'b0) begin fails++; $display("FAIL basic_read_done got %b want 0", RDY_read_prt_entry); end
  endtask

  task automatic test_full();
    for (int i = 0; i < 15; i++) begin
      do_start_write();
      EN_write_prt_entry = 1; EN_finish_writing_prt_entry = 1; write_prt_entry_data = $urandom; tick();
    end
    tests++;
    if ({is_prt_slot_free, RDY_start_writing_prt_entry} !== 2'b00) begin
      fails++; $display("FAIL full_flags got %b want 00", {is_prt_slot_free, RDY_start_writing_prt_entry});
    end
    do_inv(5);
    tests++;
    if ({RDY_start_writing_prt_entry, start_writing_prt_entry} !== {1'b1, 4'd5}) begin
      fails++; $display("FAIL full_realloc got %b/%0d want 1/5", RDY_start_writing_prt_entry, start_writing_prt_entry);
    end
    // invalidate and allocate together: allocation uses the pre-edge choice (5)
    EN_start_writing_prt_entry = 1; EN_invalidate_prt_entry = 1; invalidate_prt_entry_slot = 4'd7; tick();
    EN_write_prt_entry = 1; EN_finish_writing_prt_entry = 1; write_prt_entry_data = 32'h5555_0005; tick();
    tests++;
    if (start_writing_prt_entry !== 4'd7) begin
      fails++; $display("FAIL inv_plus_alloc got %0d want 7", start_writing_prt_entry);
    end
    do_start_read(5);
    tests++;
    if (read_prt_entry !== {1'b1, 32'h5555_0005}) begin
      fails++; $display("FAIL inv_plus_alloc_data got %h want %h", read_prt_entry, {1'b1, 32'h5555_0005});
    end
    EN_read_prt_entry = 1; tick();
  endtask

  task automatic test_max_beats();
    int s;
    s = int'(start_writing_prt_entry);
    do_start_write();
    for (int i = 0; i < 16; i++) begin
      tests++;
      if (RDY_write_prt_entry !== 1'b1) begin fails++; $display("FAIL max_rdy_write beat %0d got 0 want 1", i); end
      do_write($urandom);
    end
    tests++;
    if ({RDY_write_prt_entry, RDY_finish_writing_prt_entry} !== 2'b01) begin
      fails++; $display("FAIL max_saturate got %b want 01", {RDY_write_prt_entry, RDY_finish_writing_prt_entry});
    end
    do_write(32'hDEAD_BEEF);  // ignored: counter saturated
    do_finish();
    do_start_read(s);
    for (int i = 0; i < 16; i++) begin
      tests++;
      if (read_prt_entry !== {i == 15, mdata[s][i]}) begin
        fails++; $display("FAIL max_read beat %0d got %h want %h", i, read_prt_entry, {i == 15, mdata[s][i]});
      end
      EN_read_prt_entry = 1; tick();
    end
    tests++;
    if (RDY_read_prt_entry !== 1'b0) begin fails++; $display("FAIL max_read_done got 1 want 0"); end
  endtask

  task automatic test_invalid_and_empty();
    int s;
    do_inv(3);
    do_start_read(3);
    tests++;
    if ({RDY_read_prt_entry, read_prt_entry} !== {1'b1, 1'b1, 32'd0}) begin
      fails++; $display("FAIL invalid_read got %b/%h want 1/100000000", RDY_read_prt_entry, read_prt_entry);
    end
    EN_read_prt_entry = 1; tick();
    tests++;
    if (RDY_read_prt_entry !== 1'b0) begin fails++; $display("FAIL invalid_read_single got 1 want 0"); end
    s = int'(start_writing_prt_entry);
    do_start_write(); do_finish();
    tests++;
    if ({is_prt_slot_free, start_writing_prt_entry} !== {1'b1, 4'(s)}) begin
      fails++; $display("FAIL empty_finish got %0d want %0d", start_writing_prt_entry, s);
    end
    // finish and start_reading the same slot together: read sees it invalid
    do_start_write(); do_write($urandom);
    EN_finish_writing_prt_entry = 1; EN_start_reading_prt_entry = 1; start_reading_prt_entry_slot = 4'(s); tick();
    tests++;
    if (read_prt_entry !== {1'b1, 32'd0}) begin
      fails++; $display("FAIL finish_read_race got %h want 100000000", read_prt_entry);
    end
    EN_read_prt_entry = 1; tick();
  endtask

  task automatic test_abort();
    int s;
    do_start_read(0);
    tests++;
    if (RDY_invalidate_prt_entry !== 1'b0) begin fails++; $display("FAIL inv_blocked_in_read got 1 want 0"); end
    EN_invalidate_prt_entry = 1; invalidate_prt_entry_slot = 4'd0; EN_read_prt_entry = 1; tick();
    while (mr_open) begin EN_read_prt_entry = 1; tick(); end
    do_start_read(0);
    tests++;
    if (read_prt_entry !== m_read() || mrinv) begin
      fails++; $display("FAIL read_keeps_valid got %h want %h", read_prt_entry, m_read());
    end
    while (mr_open) begin EN_read_prt_entry = 1; tick(); end
    s = int'(start_writing_prt_entry);
    do_start_write(); do_write($urandom); do_write($urandom);
    do_inv(s);
    tests++;
    if ({RDY_write_prt_entry, RDY_finish_writing_prt_entry, is_prt_slot_free, start_writing_prt_entry}
        !== {1'b0, 1'b0, 1'b1, 4'(s)}) begin
      fails++; $display("FAIL abort got w%b f%b free%b slot%0d want w0 f0 free1 slot%0d",
        RDY_write_prt_entry, RDY_finish_writing_prt_entry, is_prt_slot_free, start_writing_prt_entry, s);
    end
  endtask

  task automatic test_random();
    int lf;
    for (int n = 0; n < 800; n++) begin
      lf = m_lowest_free();
      tests++;
      if (RDY_start_writing_prt_entry !== (!mw_open && lf >= 0) ||
          (RDY_start_writing_prt_entry && start_writing_prt_entry !== 4'(lf)) ||
          RDY_write_prt_entry !== (mw_open && mwcnt < 16) ||
          RDY_finish_writing_prt_entry !== mw_open ||
          RDY_invalidate_prt_entry !== !mr_open || RDY_start_reading_prt_entry !== !mr_open ||
          RDY_read_prt_entry !== mr_open || read_prt_entry !== m_read() ||
          is_prt_slot_free !== (lf >= 0) || RDY_is_prt_slot_free !== 1'b1) begin
        fails++;
        $display("FAIL random cyc %0d got sw%b/%0d w%b f%b i%b sr%b r%b rd%h free%b want sw%b/%0d w%b f%b r%b rd%h free%b",
          n, RDY_start_writing_prt_entry, start_writing_prt_entry, RDY_write_prt_entry,
          RDY_finish_writing_prt_entry, RDY_invalidate_prt_entry, RDY_start_reading_prt_entry,
          RDY_read_prt_entry, read_prt_entry, is_prt_slot_free,
          !mw_open && lf >= 0, lf, mw_open && mwcnt < 16, mw_open, mr_open, m_read(), lf >= 0);
      end
      EN_start_writing_prt_entry  = ($urandom_range(2) == 0);
      EN_write_prt_entry          = $urandom_range(1);
      EN_finish_writing_prt_entry = ($urandom_range(5) == 0);
      EN_invalidate_prt_entry     = ($urandom_range(7) == 0);
      EN_start_reading_prt_entry  = ($urandom_range(3) == 0);
      EN_read_prt_entry           = $urandom_range(1);
      write_prt_entry_data         = $urandom;
      invalidate_prt_entry_slot    = 4'($urandom_range(15));
      start_reading_prt_entry_slot = 4'($urandom_range(15));
      tick();
    end
  endtask

  task automatic test_reset_mid();
    do_start_read(0);
    if (!mw_open) do_start_write();
    do_write($urandom);
    #2 rst_n = 0;
    #1;
    tests++;
    if (out_vec() !== RESET_VEC) begin
      fails++; $display("FAIL reset_mid got %h want %h", out_vec(), RESET_VEC);
    end
    m_reset();
    @(negedge clk); rst_n = 1;
    @(posedge clk); #1;
    do_start_read(0);
    tests++;
    if (read_prt_entry !== {1'b1, 32'd0} || start_writing_prt_entry !== 4'd0) begin
      fails++; $display("FAIL reset_mid_freed got %h/%0d want 100000000/0", read_prt_entry, start_writing_prt_entry);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_full();
    test_max_beats();
    test_invalid_and_empty();
    test_abort();
    test_random();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
